// File: rtl/bcd7_pkg.sv
// Shared types and segment constants for the BCD 7-segment scan driver.
package bcd7_pkg;

  typedef logic [3:0] bcd_t;

  // One display position as held in the shadow/active buffers.
  typedef struct packed {
    logic dp;
    bcd_t dig;
  } disp_t;

  // Segment patterns {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam bit ACT_LOW  = 1'b1;
  localparam bit ACT_HIGH = 1'b0;

  // XOR mask that turns an active-high segment vector into the pin polarity.
  function automatic logic [6:0] seg_mask(input bit act_low);
    return act_low ? 7'h7F : 7'h00;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-high 7-segment decoder; codes 10..15 show a dash.
module bcd_to_7seg
  import bcd7_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed 7-segment driver: prescaler, digit scan, tear-free
// shadow/active buffer, leading-zero and anti-ghost blanking.
module bcd_7seg_scan_driver
  import bcd7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 1,
  parameter bit SEG_ACTIVE_LOW = ACT_LOW,
  parameter bit DIG_ACTIVE_LOW = ACT_LOW
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] scan_idx,
  output logic                    frame_done
);

  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [6:0]            SEG_INV = seg_mask(SEG_ACTIVE_LOW);
  localparam logic [NUM_DIGITS-1:0] DIG_INV = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  logic [PW-1:0]                    presc_q, presc_d;
  logic [SW-1:0]                    scan_q, scan_d;
  disp_t [NUM_DIGITS-1:0]           shadow_q, shadow_d, active_q, active_d, load_v;
  logic [6:0]                       seg_q, seg_d;
  logic                             dp_q, dp_d, fd_q, fd_d;
  logic [NUM_DIGITS-1:0]            dig_q, dig_d, dig_hi, lz_blank;
  logic [NUM_DIGITS-1:0][6:0]       dec;
  logic [6:0]                       seg_hi;
  logic                             dp_hi, slot_tick, frame_tick, in_blank, run;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    assign load_v[i].dp  = dp_in[i];
    assign load_v[i].dig = digits_in[4*i +: 4];
    bcd_to_7seg u_dec (.bcd(active_q[i].dig), .seg(dec[i]));
  end

  // Blanking propagates downward from the top digit while digits stay zero
  // with no decimal point; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    run      = blank_lz;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run         = run && (active_q[i].dig == 4'd0) && !active_q[i].dp;
      lz_blank[i] = run;
    end
  end

  assign slot_tick  = (presc_q == PW'(SCAN_DIV - 1));
  assign frame_tick = slot_tick && (scan_q == SW'(NUM_DIGITS - 1));
  assign in_blank   = (BLANK_CYC > 0) && (presc_q < PW'(BLANK_CYC));

  always_comb begin
    presc_d  = slot_tick ? '0 : presc_q + 1'b1;
    scan_d   = scan_q;
    if (slot_tick)
      scan_d = (scan_q == SW'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;
    shadow_d = load ? load_v : shadow_q;
    // Active only changes between frames, so a frame never mixes two loads.
    active_d = frame_tick ? shadow_q : active_q;
    fd_d     = frame_tick;

    seg_hi = SEG_OFF;
    dp_hi  = 1'b0;
    dig_hi = '0;
    if (!in_blank) begin
      dig_hi[scan_q] = 1'b1;
      dp_hi          = active_q[scan_q].dp;
      if (!lz_blank[scan_q]) seg_hi = dec[scan_q];
    end
    seg_d = seg_hi ^ SEG_INV;
    dp_d  = dp_hi ^ SEG_ACTIVE_LOW;
    dig_d = dig_hi ^ DIG_INV;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc_q  <= '0;
      scan_q   <= '0;
      shadow_q <= '0;
      active_q <= '0;
      fd_q     <= 1'b0;
      seg_q    <= SEG_OFF ^ SEG_INV;
      dp_q     <= SEG_ACTIVE_LOW;
      dig_q    <= DIG_INV;
    end else begin
      presc_q  <= presc_d;
      scan_q   <= scan_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      fd_q     <= fd_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dig_q    <= dig_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_en     = dig_q;
  assign scan_idx   = scan_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Self-checking bench: cycle-count reference model of the scanned display.
module tb_bcd_7seg_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = N * DIV;

  localparam logic [6:0] TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                      7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
                                      7'h40, 7'h40, 7'h40, 7'h40};

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [4*N-1:0]    digits_in = '0;
  logic [N-1:0]      dp_in = '0;
  logic              load = 1'b0;
  logic              blank_lz = 1'b0;
  logic [6:0]        seg_out;
  logic              dp_out;
  logic [N-1:0]      dig_en;
  logic [1:0]        scan_idx;
  logic              frame_done;

  bcd_7seg_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(DIV), .BLANK_CYC(BLANK),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .digits_in(digits_in), .dp_in(dp_in),
    .load(load), .blank_lz(blank_lz), .seg_out(seg_out), .dp_out(dp_out),
    .dig_en(dig_en), .scan_idx(scan_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Model state: cycles since reset, plus shadow/active display contents.
  int          c = 0;
  int          sh_v [N];
  int          act_v [N];
  bit          sh_dp [N];
  bit          act_dp [N];
  logic [15:0] d_r = '0;
  logic [3:0]  dp_r = '0;
  bit          blz_r = 1'b0;
  int          passed = 0;
  int          total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s at cycle %0d: got %h expected %h", tag, c, got, exp);
  endtask

  task automatic step(input bit rst, input bit ld);
    logic [6:0] es;
    logic [3:0] ed;
    logic       edp, efd, blk;
    int         p, s, esc;
    rstn = !rst; load = ld; digits_in = d_r; dp_in = dp_r; blank_lz = blz_r;
    es = 7'h7F; ed = 4'hF; edp = 1'b1; efd = 1'b0; esc = 0;
    if (!rst) begin
      p = c % DIV;
      s = (c / DIV) % N;
      if (p >= BLANK) begin
        ed[s] = 1'b0;
        blk = blz_r && (s != 0);
        for (int j = s; j < N; j++) if (act_v[j] != 0 || act_dp[j]) blk = 1'b0;
        es  = blk ? 7'h7F : ~TAB[act_v[s]];
        edp = ~act_dp[s];
      end
      efd = (c % FRAME) == FRAME - 1;
      esc = ((c + 1) / DIV) % N;
    end
    @(posedge clk); #1;
    if (rst) begin
      c = 0;
      for (int j = 0; j < N; j++) begin
        sh_v[j] = 0; act_v[j] = 0; sh_dp[j] = 0; act_dp[j] = 0;
      end
    end else begin
      if (c % FRAME == FRAME - 1)
        for (int j = 0; j < N; j++) begin act_v[j] = sh_v[j]; act_dp[j] = sh_dp[j]; end
      if (ld)
        for (int j = 0; j < N; j++) begin sh_v[j] = int'(d_r[4*j +: 4]); sh_dp[j] = dp_r[j]; end
      c++;
    end
    load = 1'b0;
    chk("seg_out", 32'(seg_out), 32'(es));
    chk("dig_en", 32'(dig_en), 32'(ed));
    chk("dp_out", 32'(dp_out), 32'(edp));
    chk("scan_idx", 32'(scan_idx), 32'(esc));
    chk("frame_done", 32'(frame_done), 32'(efd));
  endtask

  initial begin
    logic [15:0] rd;
    for (int j = 0; j < N; j++) begin sh_v[j] = 0; act_v[j] = 0; sh_dp[j] = 0; act_dp[j] = 0; end
    // Reset held three cycles, then free run.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 40; k++) step(1'b0, 1'b0);
    // Plain digits, no blanking.
    d_r = 16'h1234; dp_r = 4'h0; blz_r = 1'b0; step(1'b0, 1'b1);
    for (int k = 0; k < 40; k++) step(1'b0, 1'b0);
    // Leading-zero blanking cases.
    d_r = 16'h0045; blz_r = 1'b1; step(1'b0, 1'b1);
    for (int k = 0; k < 36; k++) step(1'b0, 1'b0);
    d_r = 16'h0000; step(1'b0, 1'b1);
    for (int k = 0; k < 36; k++) step(1'b0, 1'b0);
    dp_r = 4'b0100; step(1'b0, 1'b1);
    for (int k = 0; k < 36; k++) step(1'b0, 1'b0);
    d_r = 16'h00AF; dp_r = 4'h0; step(1'b0, 1'b1);
    for (int k = 0; k < 36; k++) step(1'b0, 1'b0);
    // Two loads inside one frame: last one wins, current frame untouched.
    while (c % FRAME != 5) step(1'b0, 1'b0);
    d_r = 16'h1111; step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    d_r = 16'h2222; step(1'b0, 1'b1);
    for (int k = 0; k < 40; k++) step(1'b0, 1'b0);
    // Load on the frame boundary edge.
    while (c % FRAME != FRAME - 1) step(1'b0, 1'b0);
    d_r = 16'h9870; step(1'b0, 1'b1);
    for (int k = 0; k < 36; k++) step(1'b0, 1'b0);
    // Random loads, digits biased toward zero to exercise blanking.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(7) == 0) begin
        for (int j = 0; j < N; j++) rd[4*j +: 4] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
        d_r   = rd;
        dp_r  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
        blz_r = 1'($urandom_range(1));
        step(1'b0, 1'b1);
      end else begin
        step(1'b0, 1'b0);
      end
    end
    // Mid-frame reset during slot 2.
    while (c % FRAME != 9) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int k = 0; k < 40; k++) step(1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_7seg_scan_driver.md
Name: bcd_7seg_scan_driver

Overview:
Downstream consumer of the cascaded mod-10 digit counters. It takes NUM_DIGITS packed BCD digits and drives a time-multiplexed common-anode/cathode 7-segment display. The block contains a refresh prescaler, a digit-scan counter, a tear-free shadow/active digit buffer, leading-zero blanking and anti-ghost blanking. All display outputs are registered.

Parameters:
NUM_DIGITS, 4, number of digits scanned; range 1..8.
SCAN_DIV, 1000, clk cycles per digit slot; must be at least 2.
BLANK_CYC, 1, cycles at the start of each slot with all digits off; must be less than SCAN_DIV.
SEG_ACTIVE_LOW, 1, 1 = a segment is lit when its bit is 0.
DIG_ACTIVE_LOW, 1, 1 = a digit is enabled when its bit is 0.

Ports:
clk  input  1  clock; all logic on posedge.
rstn  input  1  synchronous, active-low reset.
digits_in  input  4*NUM_DIGITS  packed BCD; digit i is bits [4i+3:4i]; digit 0 is the least significant.
dp_in  input  NUM_DIGITS  decimal-point request per digit.
load  input  1  one-cycle strobe that captures digits_in and dp_in into the shadow buffer.
blank_lz  input  1  enables leading-zero blanking.
seg_out  output  7  {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW.
dp_out  output  1  decimal point, same polarity as seg_out.
dig_en  output  NUM_DIGITS  one-hot digit enable, polarity set by DIG_ACTIVE_LOW.
scan_idx  output  $clog2(NUM_DIGITS) (minimum 1)  index of the digit currently being scanned.
frame_done  output  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (rstn=0 at posedge):
  - prescaler=0, scan_idx=0, shadow=0, active=0.
  - frame_done=0.
  - dig_en = all inactive; seg_out and dp_out = off (all 1 when active-low).
  - Reset takes effect mid-frame with no residue.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - slot_tick is asserted while prescaler==SCAN_DIV-1. It must never reach SCAN_DIV (no off-by-one).
- Scan counter:
  - On slot_tick, scan_idx increments.
  - At NUM_DIGITS-1 it wraps to 0 on slot_tick.
- Frame boundary:
  - Defined as slot_tick with scan_idx==NUM_DIGITS-1.
  - At the same edge: active <= shadow, and frame_done=1 for exactly one cycle.
- Load:
  - load=1 captures the inputs into shadow at that edge.
  - The captured value is displayed from the next frame onward; a frame in progress never tears.
  - load coinciding with a frame boundary: active takes the old shadow, and the new value appears one frame later.
  - A later load before the boundary overwrites the earlier one; last wins.
- Output register (one-cycle latency from prescaler/scan_idx state):
  - When prescaler < BLANK_CYC: dig_en all inactive, seg_out off.
  - Otherwise: dig_en enables bit scan_idx only, and seg_out = decode(active digit[scan_idx]).
- Decode (active-high values, inverted when SEG_ACTIVE_LOW=1):
  - 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10..15 display a dash, 7'h40.
- Leading-zero blanking (blank_lz=1):
  - Digit i is blanked (seg off, digit enable still driven) when the digit is 0, every higher digit is also 0 and blanked, no dp_in is set on digit i or any higher digit, and i != 0.
  - Digit 0 is never blanked.
  - Invalid codes (10..15) count as non-zero.
- dp_out = active dp[scan_idx] during the non-blank part of a slot; otherwise off.
- When NUM_DIGITS=1, scan_idx stays 0 and every slot_tick is a frame boundary.

Decomposition:
- Package bcd7_pkg:
  - SEG_0..SEG_9, SEG_DASH and SEG_OFF constants (active-high).
  - 4-bit BCD digit typedef.
  - Polarity helper constants.
- Sub-module bcd_to_7seg: combinational 4-bit to 7-bit active-high decoder. Polarity inversion is applied in the parent.

Test Plan:
(Bench configuration for all scenarios: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, both polarities active-low.)
1. Hold rstn=0 for 3 cycles, then release -> during reset seg_out=7'h7F, dig_en=4'hF, scan_idx=0, frame_done=0. After release, scan_idx advances every 4 cycles through 0,1,2,3,0, and frame_done pulses once every 16 cycles.
2. load digits_in=16'h1234, dp_in=0, blank_lz=0 -> from the next frame:
   - slot 0: dig_en=4'b1110, seg_out=~7'h66 (digit 4);
   - slot 3: dig_en=4'b0111, seg_out=~7'h06 (digit 1);
   - the first cycle of each slot shows all digits off.
3. load 16'h0045 with blank_lz=1 -> digits 3 and 2 show seg_out=7'h7F; digits 1 and 0 show 4 and 5. Then load 16'h0000 -> only digit 0 lit, showing 0. Then set dp_in=4'b0100 -> digit 2 shows 0 with dp_out=0 (lit).
4. load 16'h00AF with blank_lz=1 -> digits 1 and 0 show dash ~7'h40; digits 3 and 2 are blank.
5. Pulse load with 16'h1111 mid-frame, then pulse load with 16'h2222 two cycles later -> the current frame is unchanged, and the next frame shows 2222.
6. Assert rstn=0 for 1 cycle during slot 2 -> the next cycle shows outputs at their reset values, and active and shadow are 0. After release, the scan restarts at idx 0 and displays 0000 (or digit 0 only when blank_lz=1).
